// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold/shift/load/rotate/ASR plus multi-cycle burst shift right.
// Optional SHIFT_SYNC_CLR_EN adds a synchronous active-high clear port sclr.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
`ifdef SHIFT_SYNC_CLR_EN
    input  logic             sclr,
`endif
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             in,
    input  logic             in_left,
    input  logic [WIDTH-1:0] r_in,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] r,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_BURST = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [AMT_W-1:0]   r_cnt;
    logic [AMT_W-1:0]   w_cnt_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   w_shr;
    logic [WIDTH-1:0]   w_shl;
    logic [WIDTH-1:0]   w_ror;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_asr;
    logic               w_amt_ok;

    // Candidate results for each single-step operation
    assign w_shr    = {in, r_data[WIDTH-1:1]};
    assign w_shl    = {r_data[WIDTH-2:0], in_left};
    assign w_ror    = {r_data[0], r_data[WIDTH-1:1]};
    assign w_rol    = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
    assign w_asr    = {r_data[WIDTH-1], r_data[WIDTH-1:1]};

    // A zero or oversized burst count degenerates to a done-only no-op
    assign w_amt_ok = (amt != '0) && (amt <= AMT_W'(WIDTH));

    // State and data registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and command decode
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    case (mode)
                        M_HOLD:  w_data_nxt = r_data;
                        M_SHR:   w_data_nxt = w_shr;
                        M_SHL:   w_data_nxt = w_shl;
                        M_LOAD:  w_data_nxt = r_in;
                        M_ROR:   w_data_nxt = w_ror;
                        M_ROL:   w_data_nxt = w_rol;
                        M_ASR:   w_data_nxt = w_asr;
                        M_BURST: begin
                            if (w_amt_ok) begin
                                w_cnt_nxt   = amt;
                                w_busy_nxt  = 1'b1;
                                w_state_nxt = S_BURST;
                            end else begin
                                w_done_nxt  = 1'b1;
                            end
                        end
                        default: w_data_nxt = r_data;
                    endcase
                end
            end
            S_BURST: begin
                // Commands are ignored; the last shift lands on the 1->0 count edge
                w_data_nxt = w_shr;
                w_cnt_nxt  = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase

`ifdef SHIFT_SYNC_CLR_EN
        if (sclr) begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = '0;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
`endif
    end

    assign r         = r_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ser_out_r = r_data[0];
    assign ser_out_l = r_data[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             clr;
`ifdef SHIFT_SYNC_CLR_EN
    logic             sclr;
`endif
    logic             en;
    logic [2:0]       mode;
    logic             in;
    logic             in_left;
    logic [WIDTH-1:0] r_in;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] r;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
`ifdef SHIFT_SYNC_CLR_EN
        .sclr      (sclr),
`endif
        .en        (en),
        .mode      (mode),
        .in        (in),
        .in_left   (in_left),
        .r_in      (r_in),
        .amt       (amt),
        .r         (r),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] er, input logic eb, input logic ed);
        check({tag, ".r"}, 32'(r), 32'(er));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic cmd(input logic [2:0] m, input logic [7:0] d);
        en   = 1'b1;
        mode = m;
        r_in = d;
        step();
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; mode = 3'b000; in = 1'b0; in_left = 1'b0;
        r_in = '0; amt = '0;
`ifdef SHIFT_SYNC_CLR_EN
        sclr = 1'b0;
`endif
        #2 clr = 1'b0;
        #1;
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        check("reset.ser_r", 32'(ser_out_r), 32'd0);
        check("reset.ser_l", 32'(ser_out_l), 32'd0);
        #4 clr = 1'b1;

        cmd(3'b011, 8'hA5);
        chk_state("load_a5", 8'hA5, 1'b0, 1'b0);
        check("load_a5.ser_r", 32'(ser_out_r), 32'd1);
        check("load_a5.ser_l", 32'(ser_out_l), 32'd1);

        // Asynchronous clear between edges
        #2 clr = 1'b0;
        #1;
        chk_state("async_clr", 8'h00, 1'b0, 1'b0);
        #1 clr = 1'b1;
        cmd(3'b011, 8'hA5);
        check("reload_a5", 32'(r), 32'hA5);

        in = 1'b1;
        cmd(3'b001, 8'h00);
        check("shr", 32'(r), 32'hD2);
        in_left = 1'b0;
        cmd(3'b010, 8'h00);
        check("shl", 32'(r), 32'hA4);
        for (int i = 0; i < 3; i++) begin
            cmd(3'b000, 8'hFF);
            check("hold", 32'(r), 32'hA4);
        end

        cmd(3'b011, 8'h81);
        cmd(3'b100, 8'h00);
        check("ror", 32'(r), 32'hC0);
        cmd(3'b101, 8'h00);
        check("rol1", 32'(r), 32'h81);
        cmd(3'b101, 8'h00);
        check("rol2", 32'(r), 32'h03);
        cmd(3'b011, 8'h80);
        cmd(3'b110, 8'h00);
        check("asr", 32'(r), 32'hC0);

        // Burst of 3 from F0 with in=0; loads during busy are ignored
        cmd(3'b011, 8'hF0);
        in  = 1'b0;
        amt = AMT_W'(3);
        cmd(3'b111, 8'h00);
        chk_state("b3_start", 8'hF0, 1'b1, 1'b0);
        cmd(3'b011, 8'hFF);
        chk_state("b3_s1", 8'h78, 1'b1, 1'b0);
        cmd(3'b011, 8'hFF);
        chk_state("b3_s2", 8'h3C, 1'b1, 1'b0);
        cmd(3'b011, 8'hFF);
        chk_state("b3_s3", 8'h1E, 1'b0, 1'b1);
        cmd(3'b011, 8'h5A);
        chk_state("after_burst_load", 8'h5A, 1'b0, 1'b0);

        amt = AMT_W'(0);
        cmd(3'b111, 8'h00);
        chk_state("amt0", 8'h5A, 1'b0, 1'b1);
        cmd(3'b000, 8'h00);
        chk_state("amt0_after", 8'h5A, 1'b0, 1'b0);
        amt = AMT_W'(9);
        cmd(3'b111, 8'h00);
        chk_state("amt9", 8'h5A, 1'b0, 1'b1);
        cmd(3'b000, 8'h00);
        chk_state("amt9_after", 8'h5A, 1'b0, 1'b0);

        en = 1'b0; mode = 3'b011; r_in = 8'h00;
        step();
        chk_state("en0", 8'h5A, 1'b0, 1'b0);

        // Burst of 5 aborted by clr after two shifts
        in  = 1'b1;
        amt = AMT_W'(5);
        cmd(3'b111, 8'h00);
        chk_state("b5_start", 8'h5A, 1'b1, 1'b0);
        step();
        chk_state("b5_s1", 8'hAD, 1'b1, 1'b0);
        step();
        chk_state("b5_s2", 8'hD6, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        chk_state("b5_abort", 8'h00, 1'b0, 1'b0);
        mode = 3'b011; r_in = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("b5_held", 8'h00, 1'b0, 1'b0);
        end
        #2 clr = 1'b1;
        step();
        chk_state("post_abort_load", 8'h3C, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk_state("post_abort_idle", 8'h3C, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
